thermometer_decoder: RTL and testbench

Receiving end of the LED fill-bar interface. Samples a WIDTH-bit thermometer-coded bar (bits fill from bit 0 upward, all-ones then clears to zero), synchronizes and debounces it, and validates the code. Decodes it back to a binary level and counts full-to-empty wrap events. Sits between an external bar source (board pins or a neighbouring fill-bar driver) and the status/display logic.

---
 rtl/thermometer_pkg.sv | 28 ++
 rtl/bus_synchronizer.sv | 23 ++
 rtl/thermometer_decoder.sv | 104 ++++++++++
 tb/tb_thermometer_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/thermometer_pkg.sv
// Shared types and helper functions for the thermometer-bar receiver.
package thermometer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMMIT
  } state_t;

  // Helpers operate on a fixed 64-bit container, so bars up to 63 bits wide are supported.
  localparam int MAX_WIDTH = 63;

  function automatic int level_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic is_thermometer(input logic [MAX_WIDTH:0] p);
    return (p & (p + 64'd1)) == '0;
  endfunction

  function automatic int popcount(input logic [MAX_WIDTH:0] p);
    int n;
    n = 0;
    for (int i = 0; i <= MAX_WIDTH; i++) n += int'(p[i]);
    return n;
  endfunction

endpackage

// File: rtl/bus_synchronizer.sv
// Two-flop synchronizer for a multi-bit bus.
// Each bit is synchronized on its own; bits can land on different edges.
module bus_synchronizer #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] sync1,
  output logic [WIDTH-1:0] sync2
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus;
      sync2 <= sync1;
    end
  end

endmodule

// File: rtl/thermometer_decoder.sv
// Receives an asynchronous thermometer-coded fill bar, debounces and validates it,
// then reports the decoded level and counts full-to-empty wrap events.
module thermometer_decoder
  import thermometer_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int STABLE_CYCLES = 4,
  parameter int LEVEL_W       = level_width(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   io_bar,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic               code_error,
  output logic [7:0]         wrap_count,
  output logic               full,
  output logic               empty
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(WIDTH);

  logic [WIDTH-1:0]   sync1;
  logic [WIDTH-1:0]   sync2;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   cand;
  logic [CNT_W-1:0]   stab_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               cand_legal;
  logic [LEVEL_W-1:0] cand_level;
  state_t             state;

  bus_synchronizer #(.WIDTH(WIDTH)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (io_bar),
    .sync1   (sync1),
    .sync2   (sync2)
  );

  // sync1 is the value sync2 takes next, so comparing them counts how long sync2 has held.
  always_comb begin
    cnt_next = '0;
    if (sync1 == sync2) begin
      cnt_next = (stab_cnt == CNT_MAX) ? CNT_MAX : stab_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stab_cnt <= '0;
    else          stab_cnt <= cnt_next;
  end

  assign cand_legal = is_thermometer(64'(cand));
  assign cand_level = LEVEL_W'(popcount(64'(cand)));

  // Commit is decided one edge early from cnt_next so outputs land STABLE_CYCLES+2 edges after the input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cand        <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      code_error  <= 1'b0;
      wrap_count  <= '0;
    end else begin
      level_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_SETTLE: begin
          if (sync2 == acc) begin
            state <= ST_IDLE;
          end else if (cnt_next == CNT_MAX) begin
            state <= ST_COMMIT;
            cand  <= sync2;
          end else begin
            state <= ST_SETTLE;
          end
        end
        ST_COMMIT: begin
          acc <= cand;
          if (cand_legal) begin
            if ((level == LEVEL_FULL) && (cand_level == '0)) begin
              wrap_count <= wrap_count + 8'd1;
            end
            level       <= cand_level;
            level_valid <= 1'b1;
            code_error  <= 1'b0;
          end else begin
            code_error <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);

endmodule

// File: tb/tb_thermometer_decoder.sv
// Directed and randomized checks of thermometer_decoder against a behavioural model
// that decodes bars by matching them against 2**k-1 patterns.
module tb_thermometer_decoder;

  localparam int WIDTH         = 24;
  localparam int STABLE_CYCLES = 4;
  localparam int COMMIT_EDGE   = STABLE_CYCLES + 2;
  localparam int WINDOW        = 10;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] io_bar;
  logic [4:0]       level;
  logic             level_valid;
  logic             code_error;
  logic [7:0]       wrap_count;
  logic             full;
  logic             empty;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int               m_level = 0;
  int               m_wrap  = 0;
  bit               m_err   = 1'b0;
  logic [WIDTH-1:0] m_acc   = '0;

  thermometer_decoder #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .io_bar      (io_bar),
    .level       (level),
    .level_valid (level_valid),
    .code_error  (code_error),
    .wrap_count  (wrap_count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_output({tag, "_level"}, 32'(level), 32'(m_level));
    check_output({tag, "_code_error"}, 32'(code_error), 32'(m_err));
    check_output({tag, "_wrap"}, 32'(wrap_count), 32'(m_wrap));
    check_output({tag, "_full"}, 32'(full), 32'(m_level == WIDTH));
    check_output({tag, "_empty"}, 32'(empty), 32'(m_level == 0));
  endtask

  // Legal bars are exactly 2**k-1 for k in 0..WIDTH; k is then the level.
  function automatic bit ref_decode(input logic [WIDTH-1:0] p, output int lvl);
    logic [WIDTH:0] t;
    lvl = 0;
    for (int k = 0; k <= WIDTH; k++) begin
      t = ({{WIDTH{1'b0}}, 1'b1} << k) - 1'b1;
      if ({1'b0, p} == t) begin
        lvl = k;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [WIDTH-1:0] legal_bar(input int k);
    logic [WIDTH:0] t;
    t = ({{WIDTH{1'b0}}, 1'b1} << k) - 1'b1;
    return t[WIDTH-1:0];
  endfunction

  // Called right after a negedge: the next posedge is edge 0 of the new value.
  task automatic apply_stimulus(input logic [WIDTH-1:0] p, input string tag);
    int pulses;
    int pulse_at;
    int lvl;
    bit legal;
    bit exp_pulse;
    pulses   = 0;
    pulse_at = -1;
    legal    = ref_decode(p, lvl);
    exp_pulse = (p != m_acc) && legal;
    if (p != m_acc) begin
      if (legal) begin
        if (m_level == WIDTH && lvl == 0) m_wrap = (m_wrap + 1) % 256;
        m_level = lvl;
        m_err   = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_acc = p;
    end
    io_bar = p;
    for (int k = 0; k < WINDOW; k++) begin
      @(negedge clock);
      if (level_valid) begin
        pulses++;
        pulse_at = k;
      end
      if (k == COMMIT_EDGE) check_state(tag);
    end
    check_output({tag, "_pulses"}, 32'(pulses), 32'(exp_pulse ? 1 : 0));
    check_output({tag, "_pulse_edge"}, 32'(pulse_at), 32'(exp_pulse ? COMMIT_EDGE : -1));
  endtask

  task automatic apply_glitch(input logic [WIDTH-1:0] p, input int len, input string tag);
    int pulses;
    pulses = 0;
    io_bar = p;
    repeat (len) @(negedge clock);
    io_bar = m_acc;
    for (int k = 0; k < WINDOW + 2; k++) begin
      @(negedge clock);
      if (level_valid) pulses++;
    end
    check_output({tag, "_pulses"}, 32'(pulses), 32'd0);
    check_state(tag);
  endtask

  initial begin
    int idle_pulses;
    logic [WIDTH-1:0] v;

    reset_n = 1'b0;
    io_bar  = '0;
    repeat (3) @(negedge clock);
    check_output("reset_valid", 32'(level_valid), 32'd0);
    check_state("reset");
    reset_n = 1'b1;

    idle_pulses = 0;
    for (int k = 0; k < 2 * WINDOW; k++) begin
      @(negedge clock);
      if (level_valid) idle_pulses++;
    end
    check_output("idle_pulses", 32'(idle_pulses), 32'd0);
    check_state("idle");

    apply_stimulus(24'h00000F, "step4");

    for (int i = 0; i < 256; i++) begin
      apply_stimulus(24'hFFFFFF, "to_full");
      apply_stimulus(24'h000000, "to_empty");
      if (i == 0) check_output("wrap_first", 32'(wrap_count), 32'd1);
    end
    check_output("wrap_rollover", 32'(wrap_count), 32'd0);

    apply_stimulus(24'h0000FF, "step8");
    apply_glitch(24'h00FFFF, 2, "short_glitch");
    apply_stimulus(24'h00FFFF, "step16");
    apply_stimulus(24'h000005, "illegal5");
    apply_stimulus(24'h000007, "recover3");
    apply_stimulus(24'hFFFFFF, "partial_full");
    apply_stimulus(24'h000007, "partial_drop");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          v = WIDTH'($urandom);
          if (v == m_acc) v = v ^ 24'h000001;
          apply_glitch(v, int'($urandom_range(1, STABLE_CYCLES - 1)), "rand_glitch");
        end
        1:       apply_stimulus(WIDTH'($urandom), "rand_raw");
        default: apply_stimulus(legal_bar(int'($urandom_range(0, WIDTH))), "rand_legal");
      endcase
    end

    apply_stimulus(24'hFFFFFF, "pre_reset_full");
    apply_stimulus(24'h000000, "pre_reset_empty");
    apply_stimulus(24'hFFFFFF, "pre_reset_full2");

    io_bar = 24'h0003FF;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    m_level = 0;
    m_wrap  = 0;
    m_err   = 1'b0;
    m_acc   = '0;
    check_output("midreset_valid", 32'(level_valid), 32'd0);
    check_state("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    apply_stimulus(24'h0003FF, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
